// File: rtl/motoro_phase_clk_gen_if.sv
// motoro_phase_clk_gen_if: control/status bundle for the multi-phase commutation clock generator
interface motoro_phase_clk_gen_if #(
   parameter int CNT_W  = 16,
   parameter int PHASES = 3
);
   logic                          en;
   logic                          dir;
   logic                          load;
   logic [CNT_W-1:0]              div_in;
   logic [PHASES-1:0]             phase_out;
   logic                          step_tick;
   logic [$clog2(2*PHASES)-1:0]   step_idx;
   logic                          pend;
   modport master (output en, dir, load, div_in, input phase_out, step_tick, step_idx, pend);
   modport slave  (input en, dir, load, div_in, output phase_out, step_tick, step_idx, pend);
endinterface

// File: rtl/motoro_phase_clk_gen.sv
// motoro_phase_clk_gen: programmable divider walking a 2*PHASES step ring into staggered phase outputs
// Optional rising-edge dead time per phase is enabled with MOTORO_PGEN_DEADTIME_EN.
module motoro_phase_clk_gen #(
   parameter int CNT_W    = 16,
   parameter int PHASES   = 3,
   parameter int DIV_RST  = 4,
   parameter int DEAD_CYC = 2
) (
   input logic clk50mhz,
   input logic rst,
   motoro_phase_clk_gen_if.slave bus
);
   localparam int N  = 2 * PHASES;
   localparam int SW = $clog2(N);

   logic [CNT_W-1:0]  cnt, div_reg, pend_val;
   logic [SW-1:0]     step_nxt;
   logic [PHASES-1:0] dec;
   logic              expiry;

   function automatic logic [PHASES-1:0] decode(input logic [SW-1:0] s);
      logic [PHASES-1:0] d;
      d = '0;
      for (int k = 0; k < PHASES; k++) d[k] = ((int'(s) + N - 2 * k) % N) < PHASES;
      return d;
   endfunction

   // Expiry detection, next ring position and its phase decode
   always_comb begin
      expiry   = bus.en && cnt == '0;
      step_nxt = !expiry ? bus.step_idx
               : bus.dir ? (bus.step_idx == '0 ? SW'(N - 1) : bus.step_idx - SW'(1))
               : (bus.step_idx == SW'(N - 1) ? '0 : bus.step_idx + SW'(1));
      dec      = decode(step_nxt);
   end

   // Divider, ratio reload/pending logic, ring position and step pulse
   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         cnt           <= CNT_W'(DIV_RST);
         div_reg       <= CNT_W'(DIV_RST);
         pend_val      <= '0;
         bus.pend      <= 1'b0;
         bus.step_idx  <= '0;
         bus.step_tick <= 1'b0;
      end else if (!bus.en) begin
         bus.step_tick <= 1'b0;
         if (bus.load) begin
            div_reg  <= bus.div_in;
            cnt      <= bus.div_in;
            bus.pend <= 1'b0;
         end else begin
            cnt <= div_reg;
         end
      end else if (expiry) begin
         bus.step_idx  <= step_nxt;
         bus.step_tick <= 1'b1;
         bus.pend      <= 1'b0;
         if (bus.load) begin
            div_reg <= bus.div_in;
            cnt     <= bus.div_in;
         end else if (bus.pend) begin
            div_reg <= pend_val;
            cnt     <= pend_val;
         end else begin
            cnt <= div_reg;
         end
      end else begin
         bus.step_tick <= 1'b0;
         cnt           <= cnt - CNT_W'(1);
         if (bus.load) begin
            pend_val <= bus.div_in;
            bus.pend <= 1'b1;
         end
      end
   end

`ifdef MOTORO_PGEN_DEADTIME_EN
   localparam int DW = $clog2(DEAD_CYC + 1) + 1;
   logic [DW-1:0] dcnt [PHASES];

   // Phase levels: falls follow decode at once, rises wait DEAD_CYC cycles of steady high decode
   always_ff @(posedge clk50mhz) begin
      if (rst || !bus.en) begin
         bus.phase_out <= '0;
         for (int k = 0; k < PHASES; k++) dcnt[k] <= '0;
      end else begin
         for (int k = 0; k < PHASES; k++) begin
            if (!dec[k]) begin
               bus.phase_out[k] <= 1'b0;
               dcnt[k]          <= '0;
            end else if (!bus.phase_out[k]) begin
               if (dcnt[k] == DW'(DEAD_CYC)) bus.phase_out[k] <= 1'b1;
               else dcnt[k] <= dcnt[k] + DW'(1);
            end
         end
      end
   end
`else
   // Phase levels follow the decode of the next ring position directly
   always_ff @(posedge clk50mhz) begin
      if (rst || !bus.en) bus.phase_out <= '0;
      else bus.phase_out <= dec;
   end
`endif
endmodule

// File: tb/tb_motoro_phase_clk_gen.sv
// tb_motoro_phase_clk_gen: directed self-checking bench for the commutation clock generator
module tb_motoro_phase_clk_gen;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n;
   logic [2:0] exp_ph [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

   motoro_phase_clk_gen_if #(.CNT_W(16), .PHASES(3)) bus ();

   motoro_phase_clk_gen #(.CNT_W(16), .PHASES(3), .DIV_RST(4), .DEAD_CYC(2)) dut (
      .clk50mhz(clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_step(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!bus.step_tick && cnt < 40);
      check("step_seen", 32'(bus.step_tick), 32'd1);
   endtask

   task automatic step_check(input string tag, input int exp_n, input int idx);
      wait_step(n);
      check({tag, "_period"}, n, exp_n);
      check({tag, "_idx"}, 32'(bus.step_idx), idx);
      check({tag, "_phase"}, 32'(bus.phase_out), 32'(exp_ph[idx]));
   endtask

   initial begin
      rst = 1'b1;
      bus.en = 1'b0;
      bus.dir = 1'b0;
      bus.load = 1'b0;
      bus.div_in = '0;
      tick();
      tick();
      check("rst_phase", 32'(bus.phase_out), 32'd0);
      check("rst_tick", 32'(bus.step_tick), 32'd0);
      check("rst_idx", 32'(bus.step_idx), 32'd0);
      check("rst_pend", 32'(bus.pend), 32'd0);
      rst = 1'b0;
      bus.en = 1'b1;
`ifdef MOTORO_PGEN_DEADTIME_EN
      tick();
      check("dt_e1", 32'(bus.phase_out), 32'b000);
      tick();
      check("dt_e2", 32'(bus.phase_out), 32'b000);
      tick();
      check("dt_e3", 32'(bus.phase_out), 32'b101);
      tick();
      tick();
      check("dt_fall", 32'(bus.phase_out), 32'b001);
      repeat (5) tick();
      check("dt_s2_e0", 32'(bus.phase_out), 32'b001);
      tick();
      check("dt_s2_e1", 32'(bus.phase_out), 32'b001);
      tick();
      check("dt_s2_e2", 32'(bus.phase_out), 32'b011);
      repeat (3) tick();
      check("dt_s3", 32'(bus.phase_out), 32'b010);
      repeat (5) tick();
      check("dt_s4_delay", 32'(bus.phase_out), 32'b010);
      rst = 1'b1;
      tick();
      check("dt_rst", 32'(bus.phase_out), 32'b000);
      check("dt_rst_idx", 32'(bus.step_idx), 32'd0);
      rst = 1'b0;
`else
      // ring walk, period 5, wrap 5->0
      tick();
      check("en_phase", 32'(bus.phase_out), 32'(exp_ph[0]));
      check("en_tick", 32'(bus.step_tick), 32'd0);
      step_check("fwd1", 4, 1);
      for (int s = 2; s <= 6; s++) step_check("fwd", 5, s % 6);
      for (int s = 1; s <= 3; s++) step_check("to3", 5, s);
      // reverse; dir only matters at expiry
      bus.dir = 1'b1;
      step_check("rev2", 5, 2);
      tick();
      bus.dir = 1'b0;
      tick();
      tick();
      check("dir_hold_idx", 32'(bus.step_idx), 32'd2);
      bus.dir = 1'b1;
      step_check("rev1", 2, 1);
      step_check("rev0", 5, 0);
      step_check("rev5", 5, 5);
      bus.dir = 1'b0;
      // pending ratio change
      tick();
      bus.load = 1'b1;
      bus.div_in = 16'd9;
      tick();
      bus.load = 1'b0;
      check("pend_set", 32'(bus.pend), 32'd1);
      tick();
      check("pend_hold", 32'(bus.pend), 32'd1);
      step_check("old_period", 2, 0);
      check("pend_clr", 32'(bus.pend), 32'd0);
      step_check("new_period", 10, 1);
      // load coincident with expiry, div 0
      repeat (9) tick();
      bus.load = 1'b1;
      bus.div_in = 16'd0;
      tick();
      bus.load = 1'b0;
      check("ld_exp_tick", 32'(bus.step_tick), 32'd1);
      check("ld_exp_idx", 32'(bus.step_idx), 32'd2);
      check("ld_exp_pend", 32'(bus.pend), 32'd0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("div0_tick", 32'(bus.step_tick), 32'd1);
         check("div0_idx", 32'(bus.step_idx), (2 + i) % 6);
         check("div0_pend", 32'(bus.pend), 32'd0);
      end
      // disable at step 2, stopped load of 4
      bus.en = 1'b0;
      tick();
      check("dis_phase", 32'(bus.phase_out), 32'd0);
      check("dis_tick", 32'(bus.step_tick), 32'd0);
      bus.load = 1'b1;
      bus.div_in = 16'd4;
      tick();
      bus.load = 1'b0;
      check("stop_ld_pend", 32'(bus.pend), 32'd0);
      repeat (5) tick();
      check("dis_phase7", 32'(bus.phase_out), 32'd0);
      check("dis_idx7", 32'(bus.step_idx), 32'd2);
      bus.en = 1'b1;
      tick();
      check("reen_phase", 32'(bus.phase_out), 32'b011);
      check("reen_tick", 32'(bus.step_tick), 32'd0);
      check("reen_idx", 32'(bus.step_idx), 32'd2);
      step_check("reen_step", 4, 3);
      // mid-run reset overrides load
      tick();
      tick();
      rst = 1'b1;
      bus.load = 1'b1;
      bus.div_in = 16'd7;
      tick();
      check("mrst_phase", 32'(bus.phase_out), 32'd0);
      check("mrst_idx", 32'(bus.step_idx), 32'd0);
      check("mrst_tick", 32'(bus.step_tick), 32'd0);
      check("mrst_pend", 32'(bus.pend), 32'd0);
      rst = 1'b0;
      bus.load = 1'b0;
      tick();
      check("mrst_en_phase", 32'(bus.phase_out), 32'(exp_ph[0]));
      step_check("mrst_step", 4, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
